// File: rtl/charger_pkg.sv
// Shared types for the charger session controller: state codes and idle counter width.
package charger_pkg;
   localparam int IDLE_W = 8;

   typedef enum logic [2:0] {
      ST_OFF     = 3'd0,
      ST_READY   = 3'd1,
      ST_ENTRY   = 3'd2,
      ST_CONFIRM = 3'd3,
      ST_CHARGE  = 3'd4,
      ST_PAUSED  = 3'd5
   } state_e;
endpackage

// File: rtl/idle_countdown.sv
// Idle-timeout down-counter: clear > load > tick; value registered, zero_o is same-cycle.
// zero_o flags a tick that takes the count from 1 to 0, i.e. the timeout event.
module idle_countdown
   import charger_pkg::*;
#(
   parameter int unsigned RELOAD = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr_i,
   input  logic              load_i,
   input  logic              tick_i,
   output logic              zero_o,
   output logic [IDLE_W-1:0] cnt_o
);
   logic [IDLE_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = IDLE_W'(RELOAD);
      end else if (tick_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - IDLE_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = tick_i && (cnt_q == IDLE_W'(1));
   assign cnt_o  = cnt_q;
endmodule

// File: rtl/charge_session_ctrl.sv
// Charger session sequencer (OFF/READY/ENTRY/CONFIRM/CHARGE); all outputs registered, 1-cycle response.
// Define CHG_PAUSE_EN to enable the PAUSED state; otherwise the pause input is ignored.
module charge_session_ctrl
   import charger_pkg::*;
#(
   parameter int unsigned DIGITS     = 2,
   parameter int unsigned IDLE_TICKS = 10,
   parameter int unsigned CNT_W      = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick_1hz,
   input  logic              start,
   input  logic              digit_valid,
   input  logic              confirm,
   input  logic              cancel,
   input  logic              zero_amount,
   input  logic              charge_done,
   input  logic              pause,
   output logic [2:0]        state,
   output logic              display_en,
   output logic              charge_en,
   output logic              storage_clr,
   output logic              timer_clr,
   output logic              timer_load,
   output logic [CNT_W-1:0]  digit_cnt,
   output logic [IDLE_W-1:0] idle_left
);
   state_e             state_q, state_d;
   logic               display_en_q, display_en_d;
   logic               charge_en_q, charge_en_d;
   logic               storage_clr_q, storage_clr_d;
   logic               timer_clr_q, timer_clr_d;
   logic               timer_load_q, timer_load_d;
   logic [CNT_W-1:0]   digit_cnt_q, digit_cnt_d;
   logic               idle_load, idle_clr, idle_tick, timeout;

`ifdef CHG_PAUSE_EN
   assign idle_tick = tick_1hz &&
                      (state_q inside {ST_READY, ST_ENTRY, ST_CONFIRM, ST_PAUSED});
`else
   logic unused_pause;
   assign unused_pause = pause;
   assign idle_tick = tick_1hz && (state_q inside {ST_READY, ST_ENTRY, ST_CONFIRM});
`endif

   idle_countdown #(.RELOAD(IDLE_TICKS)) u_idle (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (idle_clr),
      .load_i (idle_load),
      .tick_i (idle_tick),
      .zero_o (timeout),
      .cnt_o  (idle_left)
   );

   always_comb begin
      state_d       = state_q;
      storage_clr_d = 1'b0;
      timer_clr_d   = 1'b0;
      timer_load_d  = 1'b0;
      digit_cnt_d   = digit_cnt_q;
      idle_load     = 1'b0;
      idle_clr      = 1'b0;
      case (state_q)
         ST_OFF: begin
            digit_cnt_d = '0;
            if (start) begin
               state_d   = ST_READY;
               idle_load = 1'b1;
            end
         end
         ST_READY: begin
            if (timeout) begin
               state_d       = ST_OFF;
               storage_clr_d = 1'b1;
               timer_clr_d   = 1'b1;
               idle_clr      = 1'b1;
            end else if (digit_valid) begin
               state_d     = (DIGITS == 1) ? ST_CONFIRM : ST_ENTRY;
               digit_cnt_d = CNT_W'(1);
               idle_load   = 1'b1;
            end
         end
         ST_ENTRY: begin
            if (cancel || timeout) begin
               state_d       = ST_READY;
               storage_clr_d = 1'b1;
               digit_cnt_d   = '0;
               idle_load     = 1'b1;
            end else if (digit_valid) begin
               digit_cnt_d = digit_cnt_q + CNT_W'(1);
               idle_load   = 1'b1;
               if (digit_cnt_d == CNT_W'(DIGITS)) state_d = ST_CONFIRM;
            end
         end
         ST_CONFIRM: begin
            // A zero payment is rejected exactly like a cancel.
            if (cancel || timeout || (confirm && zero_amount)) begin
               state_d       = ST_READY;
               storage_clr_d = 1'b1;
               digit_cnt_d   = '0;
               idle_load     = 1'b1;
            end else if (confirm) begin
               state_d      = ST_CHARGE;
               timer_load_d = 1'b1;
               idle_clr     = 1'b1;
            end
         end
         ST_CHARGE: begin
            if (cancel || charge_done) begin
               state_d       = ST_READY;
               storage_clr_d = 1'b1;
               timer_clr_d   = 1'b1;
               digit_cnt_d   = '0;
               idle_load     = 1'b1;
`ifdef CHG_PAUSE_EN
            end else if (pause) begin
               state_d   = ST_PAUSED;
               idle_load = 1'b1;
`endif
            end
         end
`ifdef CHG_PAUSE_EN
         ST_PAUSED: begin
            if (cancel || timeout) begin
               state_d       = ST_READY;
               storage_clr_d = 1'b1;
               timer_clr_d   = 1'b1;
               digit_cnt_d   = '0;
               idle_load     = 1'b1;
            end else if (pause) begin
               state_d  = ST_CHARGE;
               idle_clr = 1'b1;
            end
         end
`endif
         default: begin
            state_d     = ST_OFF;
            digit_cnt_d = '0;
            idle_clr    = 1'b1;
         end
      endcase
      display_en_d = (state_d != ST_OFF);
      charge_en_d  = (state_d == ST_CHARGE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_OFF;
         display_en_q  <= 1'b0;
         charge_en_q   <= 1'b0;
         storage_clr_q <= 1'b1;
         timer_clr_q   <= 1'b1;
         timer_load_q  <= 1'b0;
         digit_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         display_en_q  <= display_en_d;
         charge_en_q   <= charge_en_d;
         storage_clr_q <= storage_clr_d;
         timer_clr_q   <= timer_clr_d;
         timer_load_q  <= timer_load_d;
         digit_cnt_q   <= digit_cnt_d;
      end
   end

   assign state       = state_q;
   assign display_en  = display_en_q;
   assign charge_en   = charge_en_q;
   assign storage_clr = storage_clr_q;
   assign timer_clr   = timer_clr_q;
   assign timer_load  = timer_load_q;
   assign digit_cnt   = digit_cnt_q;
endmodule

// File: tb/tb_charge_session_ctrl.sv
// Directed bench for charge_session_ctrl with a session-rule model checked every cycle.
module tb_charge_session_ctrl;
   localparam int DIG  = 2;
   localparam int IDLE = 10;
   localparam int CW   = 3;
`ifdef CHG_PAUSE_EN
   localparam bit PAUSE = 1'b1;
`else
   localparam bit PAUSE = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic tick_1hz = 1'b0, start = 1'b0, digit_valid = 1'b0, confirm = 1'b0;
   logic cancel = 1'b0, zero_amount = 1'b0, charge_done = 1'b0, pause = 1'b0;
   logic [2:0]    state;
   logic          display_en, charge_en, storage_clr, timer_clr, timer_load;
   logic [CW-1:0] digit_cnt;
   logic [7:0]    idle_left;

   int checks = 0;
   int errors = 0;
   bit run = 1'b0;

   charge_session_ctrl #(.DIGITS(DIG), .IDLE_TICKS(IDLE), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .start(start),
      .digit_valid(digit_valid), .confirm(confirm), .cancel(cancel),
      .zero_amount(zero_amount), .charge_done(charge_done), .pause(pause),
      .state(state), .display_en(display_en), .charge_en(charge_en),
      .storage_clr(storage_clr), .timer_clr(timer_clr), .timer_load(timer_load),
      .digit_cnt(digit_cnt), .idle_left(idle_left)
   );

   always #5 clk = ~clk;

   typedef struct {
      int st;
      int cnt;
      int idle;
      bit sclr;
      bit tclr;
      bit tload;
   } mdl_t;

   mdl_t m;

   function automatic mdl_t back_to_ready(mdl_t n, bit clr_timer);
      n.st = 1; n.cnt = 0; n.idle = IDLE; n.sclr = 1'b1; n.tclr = clr_timer;
      return n;
   endfunction

   // Session rules: the user has IDLE ticks to act while waiting for input or paused.
   function automatic mdl_t model_next(mdl_t c, bit s, bit dv, bit cf, bit cn, bit tk,
                                       bit ps, bit za, bit cd);
      mdl_t n;
      bit waiting, to;
      n = c; n.sclr = 1'b0; n.tclr = 1'b0; n.tload = 1'b0;
      waiting = (c.st >= 1 && c.st <= 3) || (PAUSE && c.st == 5);
      to = waiting && tk && (c.idle == 1);
      if (waiting && tk && c.idle > 0) n.idle = c.idle - 1;
      case (c.st)
         0: if (s) begin n.st = 1; n.cnt = 0; n.idle = IDLE; end
         1: if (to) begin
               n.st = 0; n.idle = 0; n.sclr = 1'b1; n.tclr = 1'b1;
            end else if (dv) begin
               n.cnt = 1; n.idle = IDLE; n.st = (DIG == 1) ? 3 : 2;
            end
         2: if (cn || to) n = back_to_ready(n, 1'b0);
            else if (dv) begin
               n.cnt = c.cnt + 1; n.idle = IDLE; n.st = (n.cnt == DIG) ? 3 : 2;
            end
         3: if (cn || to || (cf && za)) n = back_to_ready(n, 1'b0);
            else if (cf) begin n.st = 4; n.tload = 1'b1; n.idle = 0; end
         4: if (cn || cd) n = back_to_ready(n, 1'b1);
            else if (PAUSE && ps) begin n.st = 5; n.idle = IDLE; end
         5: if (!PAUSE) begin n.st = 0; n.cnt = 0; n.idle = 0; end
            else if (cn || to) n = back_to_ready(n, 1'b1);
            else if (ps) begin n.st = 4; n.idle = 0; end
         default: begin n.st = 0; n.cnt = 0; n.idle = 0; end
      endcase
      return n;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m <= '{st: 0, cnt: 0, idle: 0, sclr: 1'b1, tclr: 1'b1, tload: 1'b0};
      end else begin
         m <= model_next(m, start, digit_valid, confirm, cancel, tick_1hz, pause,
                         zero_amount, charge_done);
      end
   end

   task automatic cmp(string nm, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (run) begin
         cmp("mdl_state",       int'(state),       m.st);
         cmp("mdl_display_en",  int'(display_en),  int'(m.st != 0));
         cmp("mdl_charge_en",   int'(charge_en),   int'(m.st == 4));
         cmp("mdl_storage_clr", int'(storage_clr), int'(m.sclr));
         cmp("mdl_timer_clr",   int'(timer_clr),   int'(m.tclr));
         cmp("mdl_timer_load",  int'(timer_load),  int'(m.tload));
         cmp("mdl_digit_cnt",   int'(digit_cnt),   m.cnt);
         cmp("mdl_idle_left",   int'(idle_left),   m.idle);
      end
   end

   // Drive one cycle of pulses; returns 1 time unit after the consuming edge.
   task automatic step(bit s, bit dv, bit cf, bit cn, bit tk, bit ps);
      start = s; digit_valid = dv; confirm = cf; cancel = cn; tick_1hz = tk; pause = ps;
      @(posedge clk);
      #1;
      start = 0; digit_valid = 0; confirm = 0; cancel = 0; tick_1hz = 0; pause = 0;
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0);
   endtask

   initial begin
      #1 reset = 1'b1;
      #1 run = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      cmp("rst_state", int'(state), 0);
      cmp("rst_storage_clr", int'(storage_clr), 1);
      cmp("rst_timer_clr", int'(timer_clr), 1);
      cmp("rst_idle_left", int'(idle_left), 0);
      reset = 1'b0;
      step(0, 0, 0, 0, 0, 0);
      cmp("rel_storage_clr", int'(storage_clr), 0);
      cmp("rel_timer_clr", int'(timer_clr), 0);

      step(1, 0, 0, 0, 0, 0);
      cmp("start_state", int'(state), 1);
      cmp("start_display", int'(display_en), 1);
      cmp("start_idle", int'(idle_left), 10);

      step(0, 1, 0, 0, 0, 0);
      cmp("d1_state", int'(state), 2);
      cmp("d1_cnt", int'(digit_cnt), 1);
      step(0, 1, 0, 0, 0, 0);
      cmp("d2_state", int'(state), 3);
      step(0, 0, 1, 0, 0, 0);
      cmp("cf_state", int'(state), 4);
      cmp("cf_timer_load", int'(timer_load), 1);
      cmp("cf_charge_en", int'(charge_en), 1);
      cmp("cf_idle", int'(idle_left), 0);
      step(1, 1, 1, 0, 1, 0);
      cmp("chg_ignore_state", int'(state), 4);
      cmp("chg_load_once", int'(timer_load), 0);
      charge_done = 1'b1;
      step(0, 0, 0, 0, 0, 0);
      charge_done = 1'b0;
      cmp("done_state", int'(state), 1);
      cmp("done_sclr", int'(storage_clr), 1);
      cmp("done_tclr", int'(timer_clr), 1);

      ticks(1);
      cmp("rdy_tick_idle", int'(idle_left), 9);
      step(0, 1, 0, 0, 1, 0);
      cmp("reload_wins_idle", int'(idle_left), 10);
      ticks(9);
      cmp("entry_idle1_state", int'(state), 2);
      cmp("entry_idle1", int'(idle_left), 1);
      ticks(1);
      cmp("entry_to_state", int'(state), 1);
      cmp("entry_to_sclr", int'(storage_clr), 1);
      cmp("entry_to_cnt", int'(digit_cnt), 0);

      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      cmp("cfm_ignore_digit", int'(digit_cnt), 2);
      zero_amount = 1'b1;
      step(0, 0, 1, 0, 0, 0);
      zero_amount = 1'b0;
      cmp("zero_state", int'(state), 1);
      cmp("zero_sclr", int'(storage_clr), 1);
      cmp("zero_charge_en", int'(charge_en), 0);

      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 1, 0, 0);
      cmp("cancel_state", int'(state), 1);
      cmp("cancel_cnt", int'(digit_cnt), 0);

      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
`ifdef CHG_PAUSE_EN
      cmp("pause_state", int'(state), 5);
      cmp("pause_charge_en", int'(charge_en), 0);
      cmp("pause_idle", int'(idle_left), 10);
      ticks(10);
      cmp("pause_to_state", int'(state), 1);
      cmp("pause_to_sclr", int'(storage_clr), 1);
      cmp("pause_to_tclr", int'(timer_clr), 1);
`else
      cmp("nopause_state", int'(state), 4);
      cmp("nopause_charge_en", int'(charge_en), 1);
      step(0, 0, 0, 1, 0, 0);
      cmp("chg_cancel_state", int'(state), 1);
      cmp("chg_cancel_tclr", int'(timer_clr), 1);
`endif

      ticks(10);
      cmp("rdy_to_state", int'(state), 0);
      cmp("rdy_to_display", int'(display_en), 0);
      cmp("rdy_to_tclr", int'(timer_clr), 1);
      cmp("rdy_to_idle", int'(idle_left), 0);

      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      #2 reset = 1'b1;
      #1;
      cmp("midrst_state", int'(state), 0);
      cmp("midrst_sclr", int'(storage_clr), 1);
      cmp("midrst_cnt", int'(digit_cnt), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
